// File: rtl/fire_sequencer.sv
// Fire-column hazard sequencer: OFF -> RISE -> HOLD -> FALL eruption cycle, one step per frame tick.
// Optional macro FIRE_COLLIDE_EN adds player box inputs and a registered overlap output (hit).
module fire_sequencer #(
  parameter int RISE_PX     = 120,
  parameter int STEP_PX     = 4,
  parameter int HOLD_FRAMES = 60,
  parameter int OFF_FRAMES  = 90,
  parameter int ANIM_DIV    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic [9:0] base_x,
  input  logic [8:0] base_y,
`ifdef FIRE_COLLIDE_EN
  input  logic [9:0] player_x,
  input  logic [8:0] player_y,
  input  logic [9:0] player_w,
  input  logic [8:0] player_h,
  output logic       hit,
`endif
  output logic [9:0] posx,
  output logic [8:0] posy,
  output logic       animation_state,
  output logic       isplay,
  output logic       cycle_done
);

  // state     | meaning
  // ST_OFF    | hidden, counting OFF_FRAMES ticks before the next eruption
  // ST_RISE   | visible, offset climbs by STEP_PX per tick up to RISE_PX
  // ST_HOLD   | visible at full height for HOLD_FRAMES ticks
  // ST_FALL   | visible, offset drops by STEP_PX per tick back to 0
  typedef enum logic [1:0] {ST_OFF, ST_RISE, ST_HOLD, ST_FALL} state_t;

  localparam int MAX_FR = (HOLD_FRAMES > OFF_FRAMES) ? HOLD_FRAMES : OFF_FRAMES;
  localparam int TW     = (MAX_FR > 1) ? $clog2(MAX_FR) : 1;
  localparam int AW     = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  localparam logic [TW-1:0] OFF_LAST  = TW'(OFF_FRAMES - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_FRAMES - 1);
  localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_DIV - 1);
  localparam logic [7:0]    RISE8     = 8'(RISE_PX);
  localparam logic [7:0]    STEP8     = 8'(STEP_PX);
  localparam logic [8:0]    RISE9     = 9'(RISE_PX);
  localparam logic [8:0]    STEP9     = 9'(STEP_PX);

  state_t        state;
  logic [7:0]    offset;
  logic [TW-1:0] timer;
  logic [AW-1:0] anim_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_OFF;
      offset          <= '0;
      timer           <= '0;
      anim_cnt        <= '0;
      posx            <= '0;
      posy            <= '0;
      animation_state <= 1'b0;
      isplay          <= 1'b0;
      cycle_done      <= 1'b0;
    end else begin
      cycle_done <= 1'b0;
      posx       <= base_x;
      posy       <= (base_y > {1'b0, offset}) ? (base_y - {1'b0, offset}) : 9'd0;
      isplay     <= (state != ST_OFF);

      if (!enable) begin
        state           <= ST_OFF;
        offset          <= '0;
        timer           <= '0;
        anim_cnt        <= '0;
        animation_state <= 1'b0;
      end else if (frame_tick) begin
        if (state != ST_OFF) begin
          if (anim_cnt == ANIM_LAST) begin
            anim_cnt        <= '0;
            animation_state <= ~animation_state;
          end else begin
            anim_cnt <= anim_cnt + AW'(1);
          end
        end

        unique case (state)
          ST_OFF: begin
            if (timer == OFF_LAST) begin
              timer <= '0;
              state <= ST_RISE;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          ST_RISE: begin
            if (({1'b0, offset} + STEP9) >= RISE9) begin
              offset <= RISE8;
              timer  <= '0;
              state  <= ST_HOLD;
            end else begin
              offset <= offset + STEP8;
            end
          end
          ST_HOLD: begin
            if (timer == HOLD_LAST) begin
              timer <= '0;
              state <= ST_FALL;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          ST_FALL: begin
            // Landing overrides the animation update above so OFF always starts at phase 0.
            if ({1'b0, offset} <= STEP9) begin
              offset          <= '0;
              timer           <= '0;
              state           <= ST_OFF;
              anim_cnt        <= '0;
              animation_state <= 1'b0;
              cycle_done      <= 1'b1;
            end else begin
              offset <= offset - STEP8;
            end
          end
        endcase
      end
    end
  end

`ifdef FIRE_COLLIDE_EN
  // Column box is 72 x 177 at (posx, posy); all intervals half-open, widened to avoid wrap.
  logic overlap;

  always_comb begin
    overlap = ({1'b0, player_x} < ({1'b0, posx} + 11'd72)) &&
              ({1'b0, posx} < ({1'b0, player_x} + {1'b0, player_w})) &&
              ({1'b0, player_y} < ({1'b0, posy} + 10'd177)) &&
              ({1'b0, posy} < ({1'b0, player_y} + {1'b0, player_h}));
  end

  always_ff @(posedge clk) begin
    if (rst) hit <= 1'b0;
    else     hit <= isplay && overlap;
  end
`endif

endmodule

// File: tb/tb_fire_sequencer.sv
// Self-checking bench for fire_sequencer: a tick-count model fills a scoreboard queue that is
// drained when the registered outputs settle. FIRE_COLLIDE_EN additionally exercises hit.
module tb_fire_sequencer;
  localparam int RISE_PX     = 120;
  localparam int STEP_PX     = 4;
  localparam int HOLD_FRAMES = 60;
  localparam int OFF_FRAMES  = 90;
  localparam int ANIM_DIV    = 8;
  localparam int N_MOVE      = (RISE_PX + STEP_PX - 1) / STEP_PX;
  localparam int TOTAL       = OFF_FRAMES + N_MOVE + HOLD_FRAMES + N_MOVE;

  logic       clk = 1'b0;
  logic       rst, frame_tick, enable;
  logic [9:0] base_x;
  logic [8:0] base_y;
  logic [9:0] posx;
  logic [8:0] posy;
  logic       animation_state, isplay, cycle_done;
`ifdef FIRE_COLLIDE_EN
  logic [9:0] player_x, player_w;
  logic [8:0] player_y, player_h;
  logic       hit;
`endif

  fire_sequencer #(
    .RISE_PX(RISE_PX), .STEP_PX(STEP_PX), .HOLD_FRAMES(HOLD_FRAMES),
    .OFF_FRAMES(OFF_FRAMES), .ANIM_DIV(ANIM_DIV)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .enable(enable),
    .base_x(base_x), .base_y(base_y),
`ifdef FIRE_COLLIDE_EN
    .player_x(player_x), .player_y(player_y), .player_w(player_w), .player_h(player_h),
    .hit(hit),
`endif
    .posx(posx), .posy(posy), .animation_state(animation_state),
    .isplay(isplay), .cycle_done(cycle_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] posx;
    logic [8:0] posy;
    logic       isplay;
    logic       anim;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   k      = 0;  // enabled ticks taken since the current eruption cycle began

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (k=%0d)", tag, got, want, k);
    end
  endtask

  // Model: eruption position derived purely from the tick count within the cycle.
  function automatic int model_offset(input int n);
    int r, f;
    if (n <= OFF_FRAMES) return 0;
    r = n - OFF_FRAMES;
    if (r <= N_MOVE) return (r * STEP_PX > RISE_PX) ? RISE_PX : r * STEP_PX;
    if (r <= N_MOVE + HOLD_FRAMES) return RISE_PX;
    f = r - N_MOVE - HOLD_FRAMES;
    return (RISE_PX - f * STEP_PX > 0) ? RISE_PX - f * STEP_PX : 0;
  endfunction

  function automatic bit model_vis(input int n);
    return n >= OFF_FRAMES;
  endfunction

  function automatic bit model_anim(input int n);
    if (n < OFF_FRAMES) return 1'b0;
    return bit'(((n - OFF_FRAMES) / ANIM_DIV) % 2);
  endfunction

  function automatic int model_posy(input int by, input int off);
    return (by > off) ? by - off : 0;
  endfunction

  task automatic push_expect();
    exp_t e;
    e.posx   = base_x;
    e.posy   = 9'(model_posy(int'(base_y), model_offset(k)));
    e.isplay = model_vis(k);
    e.anim   = model_anim(k);
    sb_q.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check_val("posx", posx, e.posx);
    check_val("posy", posy, e.posy);
    check_val("isplay", isplay, e.isplay);
    check_val("animation_state", animation_state, e.anim);
  endtask

  task automatic do_tick();
    bit done_exp = 1'b0;
    @(negedge clk);
    frame_tick = 1'b1;
    base_x     = 10'($urandom_range(0, 1023));
    @(negedge clk);
    frame_tick = 1'b0;
    if (enable) begin
      k++;
      if (k == TOTAL) begin
        k        = 0;
        done_exp = 1'b1;
      end
    end
    check_val("cycle_done", cycle_done, done_exp);
    check_val("animation_now", animation_state, model_anim(k));
    push_expect();
    @(negedge clk);
    check_val("cycle_done_width", cycle_done, 1'b0);
    compare_out();
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic drop_enable();
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    k = 0;
    check_val("drop_cycle_done", cycle_done, 1'b0);
    check_val("drop_anim", animation_state, 1'b0);
    push_expect();
    @(negedge clk);
    check_val("drop_no_done", cycle_done, 1'b0);
    compare_out();
    do_tick();  // tick with enable low must be ignored
    @(negedge clk);
    enable = 1'b1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    k   = 0;
    check_val("rst_posx", posx, 10'd0);
    check_val("rst_posy", posy, 9'd0);
    check_val("rst_isplay", isplay, 1'b0);
    check_val("rst_anim", animation_state, 1'b0);
    check_val("rst_cycle_done", cycle_done, 1'b0);
    push_expect();
    @(negedge clk);
    check_val("rst_no_done", cycle_done, 1'b0);
    compare_out();
  endtask

`ifdef FIRE_COLLIDE_EN
  function automatic bit model_hit(input int px, input int py, input int pw, input int ph,
                                   input int cx, input int cy, input bit vis);
    return vis && (px < cx + 72) && (cx < px + pw) && (py < cy + 177) && (cy < py + ph);
  endfunction

  task automatic probe_hit(input string tag, input int px, input int py, input int pw, input int ph);
    @(negedge clk);
    player_x = 10'(px);
    player_y = 9'(py);
    player_w = 10'(pw);
    player_h = 9'(ph);
    @(negedge clk);
    @(negedge clk);
    check_val(tag, hit, model_hit(px, py, pw, ph, 200, model_posy(300, RISE_PX), 1'b1));
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    frame_tick = 1'b0;
    base_x     = 10'd0;
    base_y     = 9'd300;
`ifdef FIRE_COLLIDE_EN
    player_x = 10'd0;
    player_y = 9'd0;
    player_w = 10'd0;
    player_h = 9'd0;
`endif
    repeat (3) @(negedge clk);
    check_val("reset_posy", posy, 9'd0);
    check_val("reset_isplay", isplay, 1'b0);
    check_val("reset_cycle_done", cycle_done, 1'b0);
`ifdef FIRE_COLLIDE_EN
    check_val("reset_hit", hit, 1'b0);
`endif
    rst    = 1'b0;
    enable = 1'b1;

    // Full eruption at base_y = 300.
    run_ticks(TOTAL);
    check_val("cycle_end_isplay", isplay, 1'b0);

    // Low column: posy must clamp at 0 through the top of the eruption.
    base_y = 9'd50;
    run_ticks(OFF_FRAMES + N_MOVE);
    check_val("clamp_no_wrap", posy != 9'd511, 1'b1);
    check_val("clamp_top", posy, 9'd0);
    run_ticks(TOTAL - OFF_FRAMES - N_MOVE);

    // Enable dropped mid-HOLD, then a full OFF wait, then reset mid-RISE.
    base_y = 9'd300;
    run_ticks(OFF_FRAMES + N_MOVE + 20);
    drop_enable();
    run_ticks(OFF_FRAMES + 10);
    pulse_reset();
    run_ticks(OFF_FRAMES - 1);
    check_val("rewait_hidden", isplay, 1'b0);
    run_ticks(2);
    check_val("rewait_visible", isplay, 1'b1);

`ifdef FIRE_COLLIDE_EN
    pulse_reset();
    run_ticks(OFF_FRAMES + N_MOVE + 5);
    @(negedge clk);
    base_x = 10'd200;
    probe_hit("hit_overlap", 210, 200, 20, 20);
    probe_hit("hit_right_edge", 272, 200, 20, 20);
    probe_hit("hit_left_touch", 180, 200, 21, 20);
`endif

    check_val("scoreboard_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
